inst_mem_fetch: RTL and testbench

Parametrised synchronous instruction memory with a valid/ready fetch interface, a program-load write port, and address fault detection. Sits between the PC/fetch stage and the decoder. Replaces the free-running one-word-per-clock ROM read with a stallable, single-entry response stage, so a stalled decoder holds the fetched instruction instead of losing it.

---
 rtl/inst_mem_fetch_if.sv | 30 +++
 rtl/inst_mem_fetch.sv | 80 ++++++++
 tb/tb_inst_mem_fetch.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_mem_fetch_if.sv
// rtl/inst_mem_fetch_if.sv - fetch request, response, program-load and counter bundle
interface inst_mem_fetch_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 32
);
    localparam int IDX_W = $clog2(DEPTH);

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_inst;
    logic              rsp_err;
    logic              load_en;
    logic [IDX_W-1:0]  load_idx;
    logic [DATA_W-1:0] load_data;
    logic [15:0]       fetch_cnt;

    modport slave (
        input  req_valid, req_addr, rsp_ready, load_en, load_idx, load_data,
        output req_ready, rsp_valid, rsp_inst, rsp_err, fetch_cnt
    );

    modport master (
        output req_valid, req_addr, rsp_ready, load_en, load_idx, load_data,
        input  req_ready, rsp_valid, rsp_inst, rsp_err, fetch_cnt
    );
endinterface

// File: rtl/inst_mem_fetch.sv
// rtl/inst_mem_fetch.sv - loadable instruction memory with a stallable single-entry fetch response
module inst_mem_fetch #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 32,
    parameter int ADDR_W    = 32,
    parameter int BYTE_ADDR = 1
) (
    input  logic            clock,
    input  logic            reset_n,
    inst_mem_fetch_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {EMPTY, FULL} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic              err_q, err_d;
    logic [15:0]       cnt_q, cnt_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] idx;
    logic              fault;
    logic              accept;
    logic              complete;
    logic [DATA_W-1:0] rd_word;

    // Range check uses the full-width index so high address bits never alias low words.
    assign idx      = (BYTE_ADDR != 0) ? (bus.req_addr >> 2) : bus.req_addr;
    assign fault    = (idx >= ADDR_W'(DEPTH))
                   || ((BYTE_ADDR != 0) && (bus.req_addr[1:0] != 2'b00));
    assign rd_word  = mem_q[idx[IDX_W-1:0]];

    assign bus.req_ready = !bus.load_en && ((state_q == EMPTY) || bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;
    assign complete      = (state_q == FULL) && bus.rsp_ready;

    always_ff @(posedge clock) begin
        if (bus.load_en && (32'(bus.load_idx) < DEPTH)) begin
            mem_q[bus.load_idx] <= bus.load_data;
        end
    end

    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = FULL;
            err_d   = fault;
            inst_d  = fault ? '0 : rd_word;
        end else if (complete) begin
            state_d = EMPTY;
        end
        if (complete) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            inst_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.rsp_valid = (state_q == FULL);
    assign bus.rsp_inst  = inst_q;
    assign bus.rsp_err   = err_q;
    assign bus.fetch_cnt = cnt_q;
endmodule

// File: tb/tb_inst_mem_fetch.sv
// tb/tb_inst_mem_fetch.sv - scoreboard bench: byte-mode DEPTH=32 and word-mode DEPTH=16 instances
module tb_inst_mem_fetch;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    inst_mem_fetch_if #(.DATA_W(32), .DEPTH(32), .ADDR_W(32)) bus_a ();
    inst_mem_fetch_if #(.DATA_W(32), .DEPTH(16), .ADDR_W(32)) bus_b ();

    inst_mem_fetch #(.DATA_W(32), .DEPTH(32), .ADDR_W(32), .BYTE_ADDR(1)) dut_a (
        .clock(clock), .reset_n(reset_n), .bus(bus_a.slave));
    inst_mem_fetch #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .BYTE_ADDR(0)) dut_b (
        .clock(clock), .reset_n(reset_n), .bus(bus_b.slave));

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } rsp_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] mem_a [32];
    logic [31:0] mem_b [16];
    rsp_t q_a[$];
    rsp_t q_b[$];
    int unsigned cnt_a = 0;
    int unsigned cnt_b = 0;
    bit rr_rand = 1'b0;
    bit rr_fixed = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_fault(input logic [31:0] addr, input bit bm, input int depth);
        longint unsigned a = 64'(addr);
        longint unsigned w = bm ? a / 4 : a;
        return (bm && (a % 4 != 0)) || (w >= 64'(depth));
    endfunction

    function automatic int word_of(input logic [31:0] addr, input bit bm);
        return bm ? int'(addr / 4) : int'(addr);
    endfunction

    initial begin
        bus_a.rsp_ready = 1'b0;
        bus_b.rsp_ready = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            bus_a.rsp_ready = rr_rand ? ($urandom_range(0, 1) != 0) : rr_fixed;
            bus_b.rsp_ready = rr_rand ? ($urandom_range(0, 1) != 0) : rr_fixed;
        end
    end

    always @(negedge clock) begin
        rsp_t e;
        rsp_t got;
        if (!reset_n) begin
            q_a.delete();
            cnt_a = 0;
        end else begin
            chk("a_req_ready", bus_a.req_ready,
                !bus_a.load_en && (q_a.size() == 0 || bus_a.rsp_ready));
            chk("a_rsp_valid", bus_a.rsp_valid, q_a.size() != 0);
            chk("a_fetch_cnt", bus_a.fetch_cnt, cnt_a[15:0]);
            if (bus_a.rsp_valid && bus_a.rsp_ready) begin
                if (q_a.size() == 0) begin
                    chk("a_unexpected_rsp", 1, 0);
                end else begin
                    e = q_a.pop_front();
                    got.inst = bus_a.rsp_inst;
                    got.err  = bus_a.rsp_err;
                    chk("a_rsp_inst", got.inst, e.inst);
                    chk("a_rsp_err", got.err, e.err);
                end
                cnt_a++;
            end
            if (bus_a.load_en) mem_a[bus_a.load_idx] = bus_a.load_data;
            if (bus_a.req_valid && bus_a.req_ready) begin
                e.err  = is_fault(bus_a.req_addr, 1'b1, 32);
                e.inst = 32'h0;
                if (!e.err) e.inst = mem_a[word_of(bus_a.req_addr, 1'b1)];
                q_a.push_back(e);
            end
        end
    end

    always @(negedge clock) begin
        rsp_t e;
        rsp_t got;
        if (!reset_n) begin
            q_b.delete();
            cnt_b = 0;
        end else begin
            chk("b_req_ready", bus_b.req_ready,
                !bus_b.load_en && (q_b.size() == 0 || bus_b.rsp_ready));
            chk("b_rsp_valid", bus_b.rsp_valid, q_b.size() != 0);
            chk("b_fetch_cnt", bus_b.fetch_cnt, cnt_b[15:0]);
            if (bus_b.rsp_valid && bus_b.rsp_ready) begin
                if (q_b.size() == 0) begin
                    chk("b_unexpected_rsp", 1, 0);
                end else begin
                    e = q_b.pop_front();
                    got.inst = bus_b.rsp_inst;
                    got.err  = bus_b.rsp_err;
                    chk("b_rsp_inst", got.inst, e.inst);
                    chk("b_rsp_err", got.err, e.err);
                end
                cnt_b++;
            end
            if (bus_b.load_en) mem_b[bus_b.load_idx] = bus_b.load_data;
            if (bus_b.req_valid && bus_b.req_ready) begin
                e.err  = is_fault(bus_b.req_addr, 1'b0, 16);
                e.inst = 32'h0;
                if (!e.err) e.inst = mem_b[word_of(bus_b.req_addr, 1'b0)];
                q_b.push_back(e);
            end
        end
    end

    task automatic load_a(input int idx, input logic [31:0] d);
        bus_a.load_en = 1'b1; bus_a.load_idx = idx[4:0]; bus_a.load_data = d;
        @(posedge clock); #1;
        bus_a.load_en = 1'b0;
    endtask

    task automatic load_b(input int idx, input logic [31:0] d);
        bus_b.load_en = 1'b1; bus_b.load_idx = idx[3:0]; bus_b.load_data = d;
        @(posedge clock); #1;
        bus_b.load_en = 1'b0;
    endtask

    task automatic fetch_a(input logic [31:0] addr);
        bit acc = 1'b0;
        bus_a.req_valid = 1'b1; bus_a.req_addr = addr;
        for (int n = 0; n < 64 && !acc; n++) begin
            @(negedge clock); acc = bus_a.req_ready;
            @(posedge clock); #1;
        end
        if (!acc) chk("a_accept_timeout", 0, 1);
    endtask

    task automatic fetch_b(input logic [31:0] addr);
        bit acc = 1'b0;
        bus_b.req_valid = 1'b1; bus_b.req_addr = addr;
        for (int n = 0; n < 64 && !acc; n++) begin
            @(negedge clock); acc = bus_b.req_ready;
            @(posedge clock); #1;
        end
        if (!acc) chk("b_accept_timeout", 0, 1);
    endtask

    function automatic logic [31:0] rand_addr_a();
        logic [31:0] a;
        case ($urandom_range(0, 3))
            0, 1:    a = $urandom_range(0, 31) * 4;
            2:       a = $urandom_range(0, 31) * 4 + $urandom_range(1, 3);
            default: a = $urandom;
        endcase
        return a;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        bus_a.req_valid = 0; bus_a.req_addr = 0; bus_a.load_en = 0;
        bus_a.load_idx = 0; bus_a.load_data = 0;
        bus_b.req_valid = 0; bus_b.req_addr = 0; bus_b.load_en = 0;
        bus_b.load_idx = 0; bus_b.load_data = 0;
        #1;
        chk("rst_valid", bus_a.rsp_valid, 0);
        chk("rst_inst", bus_a.rsp_inst, 0);
        chk("rst_err", bus_a.rsp_err, 0);
        chk("rst_cnt", bus_a.fetch_cnt, 0);
        repeat (2) @(posedge clock);
        #3 reset_n = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 32; i++) load_a(i, $urandom);
        load_a(0, 32'h0000_0005); load_a(1, 32'h0000_0450);
        load_a(2, 32'h0000_0458); load_a(3, 32'h0000_0550);
        for (int i = 0; i < 16; i++) load_b(i, $urandom);

        rr_fixed = 1'b1;
        @(posedge clock); #1;
        t0 = cyc;
        fetch_a(32'd0); fetch_a(32'd4); fetch_a(32'd8); fetch_a(32'd12);
        bus_a.req_valid = 0;
        chk("b2b_cycles", cyc - t0, 4);
        repeat (2) @(posedge clock); #1;
        chk("cnt_after_four", bus_a.fetch_cnt, 4);

        rr_fixed = 1'b0;
        fetch_a(32'd8);
        bus_a.req_valid = 0;
        repeat (3) begin
            @(negedge clock);
            chk("stall_valid", bus_a.rsp_valid, 1);
            chk("stall_inst", bus_a.rsp_inst, 32'h0000_0458);
            chk("stall_ready", bus_a.req_ready, 0);
        end
        @(posedge clock); #1 rr_fixed = 1'b1;
        repeat (2) @(posedge clock); #1;
        chk("stall_cnt", bus_a.fetch_cnt, 5);

        fetch_a(32'h80); fetch_a(32'h6); fetch_a(32'hFFFF_FFFC);
        bus_a.req_valid = 0;
        repeat (2) @(posedge clock); #1;

        bus_a.load_en = 1'b1; bus_a.load_idx = 5'd2; bus_a.load_data = 32'h0000_07C0;
        bus_a.req_valid = 1'b1; bus_a.req_addr = 32'd8;
        @(negedge clock);
        chk("collide_ready", bus_a.req_ready, 0);
        @(posedge clock); #1 bus_a.load_en = 1'b0;
        fetch_a(32'd8);
        bus_a.req_valid = 0;
        repeat (2) @(posedge clock); #1;

        fetch_b(32'd15); fetch_b(32'd16); fetch_b(32'd3);
        bus_b.req_valid = 0;
        repeat (2) @(posedge clock); #1;

        rr_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                bus_a.req_valid = 0;
                load_a($urandom_range(0, 31), $urandom);
            end else begin
                fetch_a(rand_addr_a());
                if ($urandom_range(0, 2) == 0) begin
                    bus_a.req_valid = 0;
                    @(posedge clock); #1;
                end
            end
        end
        bus_a.req_valid = 0;
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                bus_b.req_valid = 0;
                load_b($urandom_range(0, 15), $urandom);
            end else begin
                fetch_b($urandom_range(0, 20));
            end
        end
        bus_b.req_valid = 0;
        rr_rand = 1'b0;
        rr_fixed = 1'b0;
        repeat (6) @(posedge clock); #1;
        rr_fixed = 1'b1;
        repeat (4) @(posedge clock); #1;

        rr_fixed = 1'b0;
        fetch_a(32'd12);
        bus_a.req_valid = 0;
        @(posedge clock); #1;
        chk("pre_reset_full", bus_a.rsp_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", bus_a.rsp_valid, 0);
        chk("async_rst_inst", bus_a.rsp_inst, 0);
        chk("async_rst_err", bus_a.rsp_err, 0);
        chk("async_rst_cnt", bus_a.fetch_cnt, 0);
        @(posedge clock); #3 reset_n = 1'b1;
        rr_fixed = 1'b1;
        @(posedge clock); #1;
        fetch_a(32'd12); fetch_a(32'd0); fetch_a(32'd4);
        bus_a.req_valid = 0;
        fetch_b(32'd3);
        bus_b.req_valid = 0;
        repeat (4) @(posedge clock); #1;
        chk("a_drained", q_a.size(), 0);
        chk("b_drained", q_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
